turn_signal_ctrl: RTL
=====================

# turn_signal_ctrl

Turn-indicator controller for the manual-transmission car model. It sits directly downstream of the 2 Hz blink divider and consumes its square-wave output, `clk_2HZ`, as `blink_src`. It debounces the left and right indicator switches and runs a four-state indicator FSM (idle, left, right, hazard). It drives the left and right indicator LEDs in phase with the divider and keeps a saturating count of lamp flashes.

## Interface
Parameters:
- `DEB_CYCLES`, default 20, is the number of consecutive clk cycles a synchronized switch must differ from its debounced value before the debounced value changes. Legal range is 1..2^20-1.

Ports:
- `clk`: input, 1 bit. System clock. This is the only clock; `blink_src` is treated as data.
- `rst`: input, 1 bit. Reset, asynchronous and active-high. Clears all state.
- `blink_src`: input, 1 bit. Square wave from the blink divider. Asynchronous to logic and synchronized internally.
- `left_sw`: input, 1 bit. Raw left-indicator switch, active-high, asynchronous.
- `right_sw`: input, 1 bit. Raw right-indicator switch, active-high, asynchronous.
- `engine_on`: input, 1 bit. Ignition level, synchronous to `clk`.
- `led_left`: output, 1 bit. Left indicator lamp, registered.
- `led_right`: output, 1 bit. Right indicator lamp, registered.
- `state_o`: output, 2 bits. Current FSM state: 0 = IDLE, 1 = LEFT, 2 = RIGHT, 3 = HAZARD.
- `flash_cnt`: output, 8 bits. Count of lamp off→on transitions, saturating.

## Operation
Input conditioning:
- `left_sw`, `right_sw` and `blink_src` each pass through a 2-flop synchronizer.
- Each switch has its own debounce counter. The counter clears whenever the synchronized value equals the debounced value.
- When the counter reaches `DEB_CYCLES`, the debounced value takes the synchronized value and the counter clears.
- A glitch shorter than `DEB_CYCLES` cycles is never seen by the FSM.
- Edge detection on the synchronized `blink_src` uses one extra register. Both rising and falling edges produce a one-cycle `blink_edge` pulse.

FSM, evaluated on the debounced values `dl` and `dr`:
- HAZARD when `dl & dr`, regardless of `engine_on`.
- Otherwise, LEFT when `dl & engine_on`.
- Otherwise, RIGHT when `dr & engine_on`.
- Otherwise IDLE.
- Any state can reach any other state in one cycle. LEFT→RIGHT goes directly, without passing through IDLE.
- `engine_on` falling while in LEFT or RIGHT forces IDLE on the next edge. HAZARD is unaffected by `engine_on`.

Blink phase:
- The 1-bit `phase` register is set to 1 on any state change into a non-IDLE state, including LEFT↔RIGHT and into or out of HAZARD. The lamp therefore lights immediately.
- While the state is unchanged and non-IDLE, `phase` toggles on each `blink_edge`.
- In IDLE, `phase` is 0.
- If a state change and a `blink_edge` occur in the same cycle, the state change wins and `phase` becomes 1.

Lamps:
- `led_left` = `phase` when the state is LEFT or HAZARD, otherwise 0.
- `led_right` = `phase` when the state is RIGHT or HAZARD, otherwise 0.

Flash counter:
- `flash_cnt` increments by 1 on every cycle where `phase` goes 0→1 in a non-IDLE state. This includes the forced 0→1 when leaving IDLE.
- The counter saturates at 255.
- It clears only on `rst`. A LEFT↔RIGHT change while `phase` is already 1 does not increment it.

## Timing
Reset values: `led_left` = 0, `led_right` = 0, `state_o` = 0, `flash_cnt` = 0, `phase` = 0. Synchronizers, debounced values and debounce counters are all 0.

Switch latency:
- A raw switch change that stays stable reaches the debounced value after 2 (sync) + `DEB_CYCLES` cycles.
- `state_o` and the LEDs update on the next edge after that, giving a total of `DEB_CYCLES` + 3 cycles.

Blink latency:
- From a `blink_src` transition to an LED toggle is 4 cycles: 2 sync, 1 edge register, 1 output register.

`engine_on` latency: a change is reflected in `state_o` and the LEDs 1 cycle later.

Reset asserted mid-blink: all outputs go to 0 immediately and asynchronously. After release, the module behaves as if the switches had just been sampled from 0, so a held switch needs the full debounce time again.

## Test plan
All scenarios use `DEB_CYCLES` = 4.
- **Reset:** hold `rst` with all inputs high → `led_left` = 0, `led_right` = 0, `state_o` = 0, `flash_cnt` = 0. Release `rst` → `state_o` = 3 exactly 7 cycles later, with both LEDs 1 and `flash_cnt` = 1.
- **Left blink:** `engine_on` = 1, raise `left_sw`, toggle `blink_src` every 20 cycles → `state_o` = 1 and `led_left` = 1 after 7 cycles. `led_left` then toggles 4 cycles after each `blink_src` edge, `led_right` stays 0, and `flash_cnt` reaches 3 after 5 edges.
- **Debounce:** with `engine_on` = 1, pulse `right_sw` for 3 cycles → no state change. Hold it for 6 cycles → `state_o` = 2.
- **Ignition cut:** `engine_on` drops while in LEFT → `state_o` = 0 and `led_left` = 0 after 1 cycle. With both switches held, `state_o` = 3 persists while `engine_on` = 0.
- **Collision:** a `blink_edge` in the same cycle as the LEFT→RIGHT change → `phase` = 1, `led_right` = 1, and `flash_cnt` unchanged if the prior `phase` was 1.
- **Saturation:** 600 `blink_src` edges in HAZARD → `flash_cnt` = 255 and stays there.

Source files
------------

// File: rtl/turn_signal_ctrl_if.sv
// ============================================================================
// turn_signal_ctrl_if : switch, blink and lamp signals of the indicator block
// Revision 1.0
// ============================================================================
`default_nettype none

interface turn_signal_ctrl_if;
  logic       blink_src;
  logic       left_sw;
  logic       right_sw;
  logic       engine_on;
  logic       led_left;
  logic       led_right;
  logic [1:0] state_o;
  logic [7:0] flash_cnt;

  modport master (
    output blink_src, left_sw, right_sw, engine_on,
    input  led_left, led_right, state_o, flash_cnt
  );

  modport slave (
    input  blink_src, left_sw, right_sw, engine_on,
    output led_left, led_right, state_o, flash_cnt
  );
endinterface

`default_nettype wire

// File: rtl/turn_signal_ctrl.sv
// ============================================================================
// turn_signal_ctrl : debounced indicator FSM with blink phase and flash count
// Revision 1.0
// ============================================================================
`default_nettype none

module turn_signal_ctrl #(
  parameter int unsigned DEB_CYCLES = 20
) (
  input  logic               clk,
  input  logic               rst,
  turn_signal_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LEFT   = 2'd1,
    ST_RIGHT  = 2'd2,
    ST_HAZARD = 2'd3
  } state_t;

  localparam int unsigned      CNT_W    = 20;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  // Index 0 is the left switch, index 1 the right switch.
  logic [1:0]       sw_raw;
  logic [1:0]       sw_sync1_q;
  logic [1:0]       sw_sync2_q;
  logic [1:0]       deb_q;
  logic [CNT_W-1:0] deb_cnt_q [2];

  logic blink_sync1_q;
  logic blink_sync2_q;
  logic blink_prev_q;
  logic blink_edge_q;

  state_t     state_q, state_d;
  logic       phase_q, phase_d;
  logic [7:0] flash_q, flash_d;
  logic       led_left_q, led_left_d;
  logic       led_right_q, led_right_d;

  assign sw_raw = {bus.right_sw, bus.left_sw};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
      deb_q      <= '0;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      sw_sync1_q <= sw_raw;
      sw_sync2_q <= sw_sync1_q;
      for (int i = 0; i < 2; i++) begin
        if (sw_sync2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DEB_LAST) begin
          deb_q[i]     <= sw_sync2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // The edge pulse is registered so an LED toggle lands exactly on the
  // same edge as a state-driven LED update would.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_sync1_q <= 1'b0;
      blink_sync2_q <= 1'b0;
      blink_prev_q  <= 1'b0;
      blink_edge_q  <= 1'b0;
    end else begin
      blink_sync1_q <= bus.blink_src;
      blink_sync2_q <= blink_sync1_q;
      blink_prev_q  <= blink_sync2_q;
      blink_edge_q  <= blink_sync2_q ^ blink_prev_q;
    end
  end

  always_comb begin
    state_d     = ST_IDLE;
    phase_d     = 1'b0;
    flash_d     = flash_q;
    led_left_d  = 1'b0;
    led_right_d = 1'b0;

    if (deb_q[0] && deb_q[1]) begin
      state_d = ST_HAZARD;
    end else if (deb_q[0] && bus.engine_on) begin
      state_d = ST_LEFT;
    end else if (deb_q[1] && bus.engine_on) begin
      state_d = ST_RIGHT;
    end

    // A state change always relights the lamp, even if a blink edge coincides.
    if (state_d != ST_IDLE) begin
      if (state_d != state_q) begin
        phase_d = 1'b1;
      end else if (blink_edge_q) begin
        phase_d = ~phase_q;
      end else begin
        phase_d = phase_q;
      end
    end

    if (phase_d && !phase_q && (flash_q != 8'hFF)) begin
      flash_d = flash_q + 8'd1;
    end

    led_left_d  = phase_d && ((state_d == ST_LEFT)  || (state_d == ST_HAZARD));
    led_right_d = phase_d && ((state_d == ST_RIGHT) || (state_d == ST_HAZARD));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      phase_q     <= 1'b0;
      flash_q     <= 8'd0;
      led_left_q  <= 1'b0;
      led_right_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      flash_q     <= flash_d;
      led_left_q  <= led_left_d;
      led_right_q <= led_right_d;
    end
  end

  assign bus.led_left  = led_left_q;
  assign bus.led_right = led_right_q;
  assign bus.state_o   = state_q;
  assign bus.flash_cnt = flash_q;

endmodule

`default_nettype wire
